pscb_stage_slice: RTL
=====================

# pscb_stage_slice

Registered pipeline slice that sits directly downstream of each `pscb_gen_stage` in the pass/switch-control generation network. Each slice:
- captures one stage's `o_data` and `o_pass` outputs;
- appends the pass bits to the accumulated switch-control word;
- forwards the not-yet-consumed scb bits for later stages, together with a transaction tag.

A valid/ready handshake with a 2-entry skid buffer gives full throughput, with no combinational ready path.

## Interface
Parameters:
- `INPUTS`, 32, network width; power of two, ≥4.
- `STAGE_NUM`, 0, index of the stage feeding this slice; range 0..STAGES-1.
- `TAG_W`, 4, width of the pass-through transaction tag.
- Derived: NODES=INPUTS/2, STAGES=$clog2(INPUTS), ACC_W=(STAGE_NUM+1)*NODES, REM_W=max(STAGES-1-STAGE_NUM,1)*NODES.

Ports:
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  synchronous clear of all buffered entries.
- `i_valid`  in  1  upstream entry valid.
- `o_ready`  out  1  slice can accept; registered.
- `i_data`  in  INPUTS  flags from stage `o_data`.
- `i_pass`  in  NODES  pass bits from stage `o_pass`.
- `i_acc`  in  max(STAGE_NUM,1)*NODES  accumulated pass bits of stages 0..STAGE_NUM-1; ignored when STAGE_NUM=0.
- `i_scb_rem`  in  REM_W  scb for stages STAGE_NUM+1.., lowest stage in LSBs.
- `i_tag`  in  TAG_W  transaction tag.
- `o_valid`  out  1  output entry valid.
- `i_ready`  in  1  downstream accepts.
- `o_data`  out  INPUTS  registered flags.
- `o_acc`  out  ACC_W  {i_pass, i_acc}; the newest stage occupies the MSBs.
- `o_scb_next`  out  NODES  scb for the next stage (low NODES of the stored scb_rem); zero when this is the last stage.
- `o_scb_rem`  out  REM_W  stored scb_rem shifted right by NODES, zero-filled.
- `o_tag`  out  TAG_W  registered tag.
- `o_occ`  out  2  buffered entries, 0..2.

## Operation
- Entry payload = {data, acc, scb_rem, tag}. Payload is formed combinationally at input and stored unmodified; output shifts are wiring only.
- Storage: main register (drives outputs) and skid register, each with a valid bit. `o_valid`=main_valid; `o_ready`=!skid_valid.
- Accept = i_valid & o_ready. Drain = o_valid & i_ready.
- Update rules:
  - Accept without drain: entry goes to main if main is empty, else to skid.
  - Drain without accept: skid moves to main; if skid is empty, main empties.
  - Accept and drain together: skid (if valid) moves to main and the new entry goes to skid; otherwise the new entry goes to main.
- Ordering strictly FIFO; no entry is lost or duplicated.
- Flush: both valids clear at the next edge; an accept in the flush cycle is discarded, and so is a drain. Flush has priority over all transfers.
- Payload registers update only on load; they are not reset, and their values are don't-care while invalid.
- Last stage (STAGE_NUM=STAGES-1): `o_scb_next` and `o_scb_rem` are tied to 0, and `o_acc` holds all STAGES*NODES pass bits.

## Timing
- Reset values: o_valid=0, o_occ=0, o_ready=1 from the first edge after release. Payload outputs are undefined after reset.
- Latency 1 cycle: an entry accepted at edge N is visible on outputs after edge N.
- Throughput 1 entry/cycle with i_ready held high.
- o_ready falls the cycle after the skid fills. With i_ready low, at most 2 entries are accepted.
- All outputs are registered or wired from registers; no input-to-output combinational path.
- Reset asserted mid-operation clears all valids asynchronously, and entries in flight are lost.

## Structure
- Shared package `pscb_pkg`:
  - `function automatic int pscb_stages(int inputs)`;
  - `localparam` helpers for ACC_W/REM_W;
  - typedef of the tag type.
- One sub-module, `pscb_skid2`: a generic 2-entry skid buffer parameterised on payload width. The slice instantiates it and handles only payload packing/unpacking and scb shifting.

## Test plan
- INPUTS=8, STAGE_NUM=0: i_data=8'hA5, i_pass=4'b1001, i_scb_rem=8'h3C, i_tag=5, i_ready=1 → one cycle later o_data=A5, o_acc=4'b1001, o_scb_next=4'hC, o_scb_rem=8'h03, o_tag=5.
- Stream 8 back-to-back entries with tags 0..7 and i_ready=1 → 8 outputs in order, o_ready never low, o_occ=1 throughout.
- Hold i_ready=0 and offer 3 entries → 2 accepted, o_occ=2, o_ready=0. Release i_ready → tags emerge in order, third entry accepted the cycle after o_ready rises.
- STAGE_NUM=2, INPUTS=8: i_acc=8'h5A, i_pass=4'h3 → o_acc=12'h35A, o_scb_next=0, o_scb_rem=0.
- Occupancy 2, then assert i_flush together with i_valid → next cycle o_occ=0, o_valid=0, o_ready=1, and the flushed-cycle entry never appears at the output.
- Drop i_rstn asynchronously mid-stream with occupancy 2 → o_valid=0 immediately, o_occ=0; after release o_ready=1 and new traffic flows.

Source files
------------

// File: rtl/pscb_pkg.sv
// Shared types and width helpers for the pass/switch-control generation network.
// Port widths are derived from these so every stage slice agrees on its layout.
package pscb_pkg;

    localparam int PSCB_TAG_W = 4;

    typedef logic [PSCB_TAG_W-1:0] pscb_tag_t;
    typedef logic [1:0]            pscb_occ_t;

    function automatic int pscb_stages(int inputs);
        return $clog2(inputs);
    endfunction

    function automatic int pscb_acc_w(int inputs, int stage_num);
        return (stage_num + 1) * (inputs / 2);
    endfunction

    // Accumulated input width; a 1-stage-wide dummy keeps stage 0 from having a zero-width port.
    function automatic int pscb_acc_in_w(int inputs, int stage_num);
        return ((stage_num < 1) ? 1 : stage_num) * (inputs / 2);
    endfunction

    function automatic int pscb_rem_w(int inputs, int stage_num);
        int rem;
        rem = pscb_stages(inputs) - 1 - stage_num;
        return ((rem < 1) ? 1 : rem) * (inputs / 2);
    endfunction

endpackage

// File: rtl/pscb_skid2.sv
// Generic 2-entry skid buffer: main register drives the outputs, skid register absorbs one
// extra entry so o_ready can be a flop with no combinational path from i_ready.
module pscb_skid2
    import pscb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output pscb_occ_t        o_occ
);

    logic             r_main_vld;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_acc;
    logic             w_drn;
    logic             w_main_ld;
    logic             w_skid_ld;
    logic [WIDTH-1:0] w_main_nxt;

    assign w_acc = i_valid & ~r_skid_vld;
    assign w_drn = r_main_vld & i_ready;

    // Main reloads when it fills from empty, or when a drain has something behind it.
    assign w_main_ld  = ~i_flush & ((w_acc & ~r_main_vld) | (w_drn & (w_acc | r_skid_vld)));
    assign w_skid_ld  = ~i_flush & w_acc & (w_drn ? r_skid_vld : r_main_vld);
    assign w_main_nxt = r_skid_vld ? r_skid : i_data;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (i_flush) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            r_main_vld <= r_main_vld ? (~w_drn | w_acc | r_skid_vld) : w_acc;
            r_skid_vld <= w_acc ? (w_drn ? r_skid_vld : r_main_vld) : (r_skid_vld & ~w_drn);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_main_ld) begin
            r_main <= w_main_nxt;
        end
        if (w_skid_ld) begin
            r_skid <= i_data;
        end
    end

    assign o_valid = r_main_vld;
    assign o_ready = ~r_skid_vld;
    assign o_data  = r_main;
    assign o_occ   = {r_main_vld & r_skid_vld, r_main_vld ^ r_skid_vld};

endmodule

// File: rtl/pscb_stage_slice.sv
// Registered slice after one pscb_gen_stage: appends the stage's pass bits to the accumulated
// switch-control word and hands the remaining scb bits on to later stages.
module pscb_stage_slice
    import pscb_pkg::*;
#(
    parameter int INPUTS    = 32,
    parameter int STAGE_NUM = 0,
    parameter int TAG_W     = 4
) (
    input  logic                                          i_clk,
    input  logic                                          i_rstn,
    input  logic                                          i_flush,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    input  logic [INPUTS-1:0]                             i_data,
    input  logic [INPUTS/2-1:0]                           i_pass,
    input  logic [pscb_acc_in_w(INPUTS, STAGE_NUM)-1:0]   i_acc,
    input  logic [pscb_rem_w(INPUTS, STAGE_NUM)-1:0]      i_scb_rem,
    input  logic [TAG_W-1:0]                              i_tag,
    output logic                                          o_valid,
    input  logic                                          i_ready,
    output logic [INPUTS-1:0]                             o_data,
    output logic [pscb_acc_w(INPUTS, STAGE_NUM)-1:0]      o_acc,
    output logic [INPUTS/2-1:0]                           o_scb_next,
    output logic [pscb_rem_w(INPUTS, STAGE_NUM)-1:0]      o_scb_rem,
    output logic [TAG_W-1:0]                              o_tag,
    output logic [1:0]                                    o_occ
);

    localparam int NODES  = INPUTS / 2;
    localparam int STAGES = pscb_stages(INPUTS);
    localparam int ACC_W  = pscb_acc_w(INPUTS, STAGE_NUM);
    localparam int REM_W  = pscb_rem_w(INPUTS, STAGE_NUM);
    localparam int PAY_W  = INPUTS + ACC_W + REM_W + TAG_W;

    logic [ACC_W-1:0] w_acc_in;
    logic [PAY_W-1:0] w_pay_in;
    logic [PAY_W-1:0] w_pay_out;
    logic [REM_W-1:0] w_rem;
    pscb_occ_t        w_occ;

    if (STAGE_NUM == 0) begin : g_first
        logic w_unused_acc;
        assign w_unused_acc = ^i_acc;
        assign w_acc_in     = i_pass;
    end else begin : g_later
        assign w_acc_in = {i_pass, i_acc};
    end

    assign w_pay_in = {i_data, w_acc_in, i_scb_rem, i_tag};

    pscb_skid2 #(
        .WIDTH (PAY_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (w_pay_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (w_pay_out),
        .o_occ   (w_occ)
    );

    assign o_occ  = w_occ;
    assign o_tag  = w_pay_out[TAG_W-1:0];
    assign w_rem  = w_pay_out[TAG_W +: REM_W];
    assign o_acc  = w_pay_out[TAG_W + REM_W +: ACC_W];
    assign o_data = w_pay_out[TAG_W + REM_W + ACC_W +: INPUTS];

    // The stored scb_rem is kept intact; consuming NODES bits per stage is pure wiring here.
    if (STAGE_NUM == STAGES - 1) begin : g_last
        logic w_unused_rem;
        assign w_unused_rem = ^w_rem;
        assign o_scb_next   = '0;
        assign o_scb_rem    = '0;
    end else begin : g_mid
        assign o_scb_next = w_rem[NODES-1:0];
        assign o_scb_rem  = w_rem >> NODES;
    end

endmodule
